// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter sharing one 32-bit memory command port between
//   NUM_REQ requesters (0 = dcache, 1 = icache, 2 = graphics fetch).
//   One transaction is latched, issued, and its completion routed back.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/addr/we/wdata  per-requester command inputs (packed, 32b lanes)
//   req_ack                  one-hot pulse: command accepted by memory
//   rsp_valid, rsp_rdata     one-hot pulse: write done / read data valid
//   mem_cmd_*, mem_addr/we/wdata, mem_rd_valid, mem_rdata  memory side
//   busy                     not in IDLE
//   err                      sticky read-timeout flag
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the read-wait
// watchdog (TIMEOUT_CYC cycles); otherwise err is tied to 0.
module mem_req_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]  req_we,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [31:0]           mem_addr,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rd_valid,
    input  logic [31:0]           mem_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int          IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [31:0]     addr_q;
    logic [3:0]      we_q;
    logic [31:0]     wdata_q;
    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic            timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt;
    logic          err_q;

    // Counter holds the number of completed WAIT_RD cycles, so the final
    // (TIMEOUT_CYC-th) wait cycle is the one where it reads TIMEOUT_CYC-1.
    // A same-cycle mem_rd_valid takes priority over the timeout.
    always_comb begin
        timeout = (state == WAIT_RD) && !mem_rd_valid &&
                  (to_cnt == CW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != WAIT_RD) to_cnt <= '0;
            else                  to_cnt <= to_cnt + 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end

    always_comb begin
        err = err_q;
    end
`else
    always_comb begin
        timeout = 1'b0;
        err     = 1'b0;
    end
`endif

    // Round-robin scan starting at rr_ptr.
    always_comb begin
        int unsigned c;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        c         = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            c = (32'(rr_ptr) + i) % NREQ_U;
            if (!gnt_found && req_valid[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(c);
            end
        end
    end

    // State register and latched transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            idx     <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_found) begin
                idx     <= gnt_idx;
                addr_q  <= req_addr[32*gnt_idx +: 32];
                we_q    <= req_we[4*gnt_idx +: 4];
                wdata_q <= req_wdata[32*gnt_idx +: 32];
            end
            if (state == ISSUE && mem_cmd_ready)
                rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = ISSUE;
            ISSUE:   if (mem_cmd_ready) state_nxt = (we_q != 4'b0000) ? IDLE : WAIT_RD;
            WAIT_RD: if (mem_rd_valid || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        mem_cmd_valid = (state == ISSUE);
        mem_addr      = addr_q;
        mem_we        = we_q;
        mem_wdata     = wdata_q;
        busy          = (state != IDLE);
        req_ack       = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        case (state)
            ISSUE: begin
                if (mem_cmd_ready) begin
                    req_ack[idx] = 1'b1;
                    if (we_q != 4'b0000) rsp_valid[idx] = 1'b1;
                end
            end
            WAIT_RD: begin
                if (mem_rd_valid) begin
                    rsp_valid[idx] = 1'b1;
                    rsp_rdata      = mem_rdata;
                end else if (timeout) begin
                    rsp_valid[idx] = 1'b1;
                    rsp_rdata      = 32'hDEADBEEF;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int N = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_addr;
    logic [N*4-1:0]  req_we;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            mem_cmd_valid;
    logic            mem_cmd_ready;
    logic [31:0]     mem_addr;
    logic [3:0]      mem_we;
    logic [31:0]     mem_wdata;
    logic            mem_rd_valid;
    logic [31:0]     mem_rdata;
    logic            busy;
    logic            err;

    mem_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          chk_data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        req_addr[i*32 +: 32] = a;
        req_we[i*4 +: 4]     = w;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic push_cmd(input int i, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        cmd_t c;
        c.idx = i; c.addr = a; c.we = w; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input int i, input logic [31:0] d, input bit chk);
        rsp_t r;
        r.idx = i; r.rdata = d; r.chk_data = chk;
        rsp_q.push_back(r);
    endtask

    // Scoreboard monitor: compares every ack/response against the queues.
    task automatic monitor();
        cmd_t c;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (req_ack != '0) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_ack", 32'(req_ack), 32'h0);
                end else begin
                    c = cmd_q.pop_front();
                    check("ack_onehot", 32'(req_ack), 32'h1 << c.idx);
                    check("cmd_valid", 32'(mem_cmd_valid), 32'h1);
                    check("cmd_addr", mem_addr, c.addr);
                    check("cmd_we", 32'(mem_we), 32'(c.we));
                    check("cmd_wdata", mem_wdata, c.wdata);
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_onehot", 32'(rsp_valid), 32'h1 << r.idx);
                    if (r.chk_data) check("rsp_rdata", rsp_rdata, r.rdata);
                end
            end
        end
    endtask

    task automatic wait_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (req_ack != '0) seen = 1'b1;
        end
        check({name, "_ack_seen"}, 32'(seen), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
        mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;
        do_reset();
        fork monitor(); join_none

        // 1: idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_outputs", {27'h0, busy, mem_cmd_valid, err, |req_ack, |rsp_valid}, 32'h0);
        end

        // 2: single write from requester 0
        @(posedge clk); #1;
        mem_cmd_ready = 1'b1;
        set_req(0, 32'h1000_0010, 4'hF, 32'hCAFE0001);
        req_valid = 3'b001;
        push_cmd(0, 32'h1000_0010, 4'hF, 32'hCAFE0001);
        push_rsp(0, 32'h0, 1'b0);
        wait_ack("wr0");
        req_valid = '0;
        @(negedge clk);
        check("wr0_busy_after", 32'(busy), 32'h0);

        // 3: read from requester 1 with command back-pressure and read latency
        @(posedge clk); #1;
        mem_cmd_ready = 1'b0;
        set_req(1, 32'h1000_0000, 4'h0, 32'h0);
        req_valid = 3'b010;
        push_cmd(1, 32'h1000_0000, 4'h0, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rd1_hold_valid", 32'(mem_cmd_valid), 32'h1);
            check("rd1_hold_addr", mem_addr, 32'h1000_0000);
            check("rd1_no_ack", 32'(req_ack), 32'h0);
            @(posedge clk); #1;
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            check("rd1_waiting_busy", 32'(busy), 32'h1);
            @(posedge clk); #1;
        end
        mem_rd_valid = 1'b1; mem_rdata = 32'h12345678;
        push_rsp(1, 32'h12345678, 1'b1);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        // stray read strobe while idle must be ignored
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        check("stray_rd_busy", 32'(busy), 32'h0);

        // 4: fairness, all three reading continuously (fresh rr_ptr)
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h2000_0000 + 32'(i * 4), 4'h0, 32'h0);
        for (int k = 0; k < 9; k++) push_cmd(k % 3, 32'h2000_0000 + 32'((k % 3) * 4), 4'h0, 32'h0);
        req_valid = 3'b111;
        for (int k = 0; k < 9; k++) begin
            wait_ack("fair");
            mem_rd_valid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
            push_rsp(k % 3, 32'hA000_0000 + 32'(k), 1'b1);
            @(posedge clk); #1;
            mem_rd_valid = 1'b0;
        end
        req_valid = '0;

        // single requester (2) granted back to back, rr_ptr wraps to 0
        @(posedge clk); #1;
        set_req(2, 32'h3000_0000, 4'h3, 32'h0000_0011);
        push_cmd(2, 32'h3000_0000, 4'h3, 32'h0000_0011);
        push_rsp(2, 32'h0, 1'b0);
        push_cmd(2, 32'h3000_0000, 4'h3, 32'h0000_0022);
        push_rsp(2, 32'h0, 1'b0);
        req_valid = 3'b100;
        wait_ack("solo_a");
        set_req(2, 32'h3000_0000, 4'h3, 32'h0000_0022);
        wait_ack("solo_b");
        req_valid = '0;

        // 5: reset during WAIT_RD; late read strobe ignored; grant restarts at 0
        @(posedge clk); #1;
        set_req(1, 32'h4000_0000, 4'h0, 32'h0);
        push_cmd(1, 32'h4000_0000, 4'h0, 32'h0);
        req_valid = 3'b010;
        wait_ack("rst_rd");
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 32'h5000_0000 + 32'(i), 4'h1, 32'h77 + 32'(i));
        push_cmd(0, 32'h5000_0000, 4'h1, 32'h77);
        push_rsp(0, 32'h0, 1'b0);
        req_valid = 3'b111;
        wait_ack("post_rst");
        req_valid = '0;

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: read timeout after 16 wait cycles, sticky err
        @(posedge clk); #1;
        begin
            int lat;
            lat = 0;
            set_req(0, 32'h6000_0000, 4'h0, 32'h0);
            push_cmd(0, 32'h6000_0000, 4'h0, 32'h0);
            push_rsp(0, 32'hDEADBEEF, 1'b1);
            req_valid = 3'b001;
            for (int k = 0; k < 30 && lat == 0; k++) begin
                @(negedge clk);
                if (req_ack != '0) lat = -1;
            end
            check("to_ack_seen", 32'(lat), 32'hFFFF_FFFF);
            lat = 0;
            for (int k = 1; k <= 30 && lat == 0; k++) begin
                @(negedge clk);
                if (rsp_valid != '0) lat = k;
            end
            check("to_latency", 32'(lat), 32'd16);
            @(posedge clk); #1;
            req_valid = '0;
            repeat (3) begin
                @(negedge clk);
                check("to_err_sticky", 32'(err), 32'h1);
            end
            @(posedge clk); #1;
            do_reset();
            @(negedge clk);
            check("to_err_cleared", 32'(err), 32'h0);
        end
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cmd_q_drained", 32'(cmd_q.size()), 32'h0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
